// File: rtl/sram_mem_controller.sv
// sram_mem_controller: splits 32-bit MEM-stage loads/stores into two timed 16-bit async SRAM transfers
module sram_mem_controller #(
  parameter int SRAM_WAIT   = 2,
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);
  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
  state_t state, state_next;
  logic [3:0] wcnt;
  logic [31:0] addr_q, wdata_q;
  logic [SRAM_ADDR_W-2:0] w;
  logic last, rd, wr, hi;
  assign last = wcnt == 4'(SRAM_WAIT - 1);
  assign rd = state == RD_LO || state == RD_HI;
  assign wr = state == WR_LO || state == WR_HI;
  assign hi = state == RD_HI || state == WR_HI;
  // word index wraps silently; out-of-range addresses alias into the SRAM
  assign w = (SRAM_ADDR_W-1)'((addr_q - 32'(BASE_ADDR)) >> 2);
  assign ready = (state == IDLE && !rd_en && !wr_en) || state == DONE;
  assign sram_we_n = !wr;
  assign sram_dq_oe = wr;
  assign sram_addr = (rd || wr) ? {w, hi} : '0;
  assign sram_dq_out = state == WR_LO ? wdata_q[15:0] : state == WR_HI ? wdata_q[31:16] : '0;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = wr_en ? WR_LO : rd_en ? RD_LO : IDLE;
      RD_LO: state_next = last ? RD_HI : RD_LO;
      RD_HI: state_next = last ? DONE : RD_HI;
      WR_LO: state_next = last ? WR_HI : WR_LO;
      WR_HI: state_next = last ? DONE : WR_HI;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
    end else begin
      state <= state_next;
      wcnt  <= ((rd || wr) && !last) ? wcnt + 4'd1 : 4'd0;
      if (state == IDLE && (wr_en || rd_en)) addr_q <= address;
      if (state == IDLE && wr_en) wdata_q <= write_data;
      if (state == RD_LO && last) read_data[15:0] <= sram_dq_in;
      if (state == RD_HI && last) read_data[31:16] <= sram_dq_in;
    end
  end
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: directed scoreboard bench with a behavioural SRAM for the MEM-stage SRAM controller
module tb_sram_mem_controller;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic rd_en, wr_en, ready, sram_dq_oe, sram_we_n;
  logic [31:0] address, write_data, read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic rd_en1, wr_en1, ready1, sram_dq_oe1, sram_we_n1;
  logic [31:0] address1, write_data1, read_data1;
  logic [17:0] sram_addr1;
  logic [15:0] sram_dq_out1, sram_dq_in1;
  sram_mem_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );
  sram_mem_controller #(.SRAM_WAIT(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1), .sram_addr(sram_addr1),
    .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1), .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
  );
  logic [15:0] mem [64] = '{default: 16'h0};
  int wc [64] = '{default: 0};
  assign sram_dq_in = mem[sram_addr[5:0]];
  assign sram_dq_in1 = sram_addr1[15:0] ^ 16'h5A5A;
  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) begin
      mem[sram_addr[5:0]] <= sram_dq_out;
      wc[sram_addr[5:0]] <= wc[sram_addr[5:0]] + 1;
    end
  int n_cmp = 0, n_err = 0;
  logic [31:0] sb [$];
  logic [31:0] ref_words [16] = '{default: 32'h0};
  logic [31:0] exp_rd = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] t;
    t = (a - 32'd1024) >> 2;
    rd_en = r; wr_en = w; address = a; write_data = d;
    if (w) ref_words[t[3:0]] = d;
    else exp_rd = ref_words[t[3:0]];
    sb.push_back(exp_rd);
  endtask
  task automatic finish(input string tag, input int exp_n);
    int n = 0;
    #1 chk({tag, " ready_c0"}, 32'(ready), 32'd0);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_n));
    chk({tag, " read_data"}, read_data, sb.pop_front());
    rd_en = 0; wr_en = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    rd_en1 = 0; wr_en1 = 0; address1 = 0; write_data1 = 0;
    repeat (2) @(negedge clk);
    chk("rst read_data", read_data, 32'h0);
    chk("rst we_n", 32'(sram_we_n), 32'd1);
    chk("rst oe", 32'(sram_dq_oe), 32'd0);
    chk("rst addr", 32'(sram_addr), 32'd0);
    chk("rst dq_out", 32'(sram_dq_out), 32'd0);
    chk("rst ready", 32'(ready), 32'd1);
    rst = 0;
    @(negedge clk);
    start(0, 1, 1024, 32'hDEADBEEF);
    finish("t1", 5);
    chk("t1 mem0", 32'(mem[0]), 32'h0000BEEF);
    chk("t1 mem1", 32'(mem[1]), 32'h0000DEAD);
    chk("t1 wc0", 32'(wc[0]), 32'd2);
    chk("t1 wc1", 32'(wc[1]), 32'd2);
    @(negedge clk);
    chk("t1 idle ready", 32'(ready), 32'd1);
    start(1, 0, 1024, 0);
    finish("t2", 5);
    @(negedge clk);
    start(0, 1, 1028, 32'h12345678);
    finish("t3w", 5);
    start(1, 0, 1028, 0);
    @(negedge clk);
    finish("t3r", 5);
    chk("t3 mem2", 32'(mem[2]), 32'h00005678);
    chk("t3 mem3", 32'(mem[3]), 32'h00001234);
    chk("t3 wc2", 32'(wc[2]), 32'd2);
    chk("t3 wc3", 32'(wc[3]), 32'd2);
    @(negedge clk);
    start(1, 1, 1032, 32'hA5A55A5A);
    finish("t4", 5);
    chk("t4 mem4", 32'(mem[4]), 32'h00005A5A);
    chk("t4 mem5", 32'(mem[5]), 32'h0000A5A5);
    @(negedge clk);
    rd_en = 0; wr_en = 1; address = 1036; write_data = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    chk("t5 in WR_HI addr", 32'(sram_addr), 32'd7);
    chk("t5 in WR_HI we_n", 32'(sram_we_n), 32'd0);
    rst = 1; wr_en = 0;
    #1;
    chk("t5 rst we_n", 32'(sram_we_n), 32'd1);
    chk("t5 rst oe", 32'(sram_dq_oe), 32'd0);
    chk("t5 rst addr", 32'(sram_addr), 32'd0);
    chk("t5 rst ready", 32'(ready), 32'd1);
    chk("t5 rst read_data", read_data, 32'h0);
    ref_words[3] = 32'h0000F00D;
    exp_rd = 0;
    @(negedge clk);
    rst = 0;
    chk("t5 mem6", 32'(mem[6]), 32'h0000F00D);
    chk("t5 mem7", 32'(mem[7]), 32'h0);
    chk("t5 wc7", 32'(wc[7]), 32'd0);
    @(negedge clk);
    start(1, 0, 1036, 0);
    finish("t5r", 5);
    @(negedge clk);
    rd_en1 = 1; address1 = 32'd525308;
    sb.push_back(32'hA5A5A5A4);
    #1 chk("t6 ready_c0", 32'(ready1), 32'd0);
    @(negedge clk);
    chk("t6 addr lo", 32'(sram_addr1), 32'h3FFFE);
    chk("t6 ready c1", 32'(ready1), 32'd0);
    @(negedge clk);
    chk("t6 addr hi", 32'(sram_addr1), 32'h3FFFF);
    @(negedge clk);
    chk("t6 ready c3", 32'(ready1), 32'd1);
    chk("t6 read_data", read_data1, sb.pop_front());
    rd_en1 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6 idle ready", 32'(ready1), 32'd1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
